// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer and the shared RV64I datapath.
// The master (controller) consumes opcode/flags/handshake and drives every select and enable.
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             mem_req;
  logic             mem_we;
  logic             iord;
  logic             ir_write;
  logic             pc_write;
  logic             pc_src;
  logic             reg_write;
  logic             mem_to_reg;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [3:0]       state;
  logic             illegal;
  logic             bus_err;
  logic [CNT_W-1:0] instr_retired;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, state, illegal,
           bus_err, instr_retired
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_src, reg_write,
           mem_to_reg, alu_src_a, alu_src_b, alu_op, state, illegal,
           bus_err, instr_retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for a shared non-pipelined RV64I datapath: sequences
// fetch/decode/execute/memory/write-back, waits on memory with a timeout, counts retirements.
module multicycle_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  multicycle_ctrl_if.master  bus
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC_R   = 4'd6,
    EXEC_I   = 4'd7,
    ALU_WB   = 4'd8,
    BRANCH   = 4'd9,
    HALT     = 4'd10
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       pc_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctl_t;

  state_t              state_q;
  state_t              nxt;
  ctl_t                ctl_q;
  logic [WAIT_W-1:0]   wcnt;
  logic [CNT_W-1:0]    retired;
  logic                illegal_q;
  logic                bus_err_q;
  logic                set_illegal;
  logic                set_bus_err;
  logic                retire;
  logic                mem_wait;
  logic                timeout_hit;

  // Moore outputs of a state; registered against the next state so they line up with state_q.
  function automatic ctl_t decode_ctl(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = 2'b01;
      end
      DECODE: begin
        c.alu_src_b = 2'b10;
      end
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      MEM_RD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.iord    = 1'b1;
      end
      EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 2'b10;
      end
      ALU_WB: begin
        c.reg_write = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.pc_src    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt         = state_q;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    retire      = 1'b0;
    mem_wait    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      FETCH: begin
        if (bus.mem_ready) nxt = DECODE;
        else               mem_wait = 1'b1;
      end
      DECODE: begin
        case (bus.opcode)
          OP_R:         nxt = EXEC_R;
          OP_I:         nxt = EXEC_I;
          OP_LD, OP_ST: nxt = MEM_ADDR;
          OP_BR:        nxt = BRANCH;
          default: begin
            nxt         = HALT;
            set_illegal = 1'b1;
          end
        endcase
      end
      MEM_ADDR: nxt = (bus.opcode == OP_LD) ? MEM_RD : MEM_WR;
      MEM_RD: begin
        if (bus.mem_ready) nxt = MEM_WB;
        else               mem_wait = 1'b1;
      end
      MEM_WB: begin
        nxt    = FETCH;
        retire = 1'b1;
      end
      MEM_WR: begin
        if (bus.mem_ready) begin
          nxt    = FETCH;
          retire = 1'b1;
        end else begin
          mem_wait = 1'b1;
        end
      end
      EXEC_R, EXEC_I: nxt = ALU_WB;
      ALU_WB, BRANCH: begin
        nxt    = FETCH;
        retire = 1'b1;
      end
      HALT: nxt = HALT;
      default: begin
        nxt         = HALT;
        set_illegal = 1'b1;
      end
    endcase
    // A ready on the limit cycle clears mem_wait, so a completing access always wins.
    if (mem_wait && (MEM_TIMEOUT != 0) && (wcnt == WAIT_W'(MEM_TIMEOUT))) begin
      timeout_hit = 1'b1;
      nxt         = HALT;
      set_bus_err = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      ctl_q     <= decode_ctl(FETCH);
      wcnt      <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      retired   <= '0;
    end else begin
      state_q <= nxt;
      ctl_q   <= decode_ctl(nxt);
      wcnt    <= (mem_wait && !timeout_hit) ? wcnt + WAIT_W'(1) : '0;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus_err) bus_err_q <= 1'b1;
      if (retire)      retired   <= retired + CNT_W'(1);
    end
  end

  // Enables are gated by rst so an access caught by reset never pulses a write.
  assign bus.mem_req    = ctl_q.mem_req   & ~rst;
  assign bus.mem_we     = ctl_q.mem_we    & ~rst;
  assign bus.reg_write  = ctl_q.reg_write & ~rst;
  assign bus.ir_write   = (state_q == FETCH) & bus.mem_ready & ~rst;
  assign bus.pc_write   = (((state_q == FETCH) & bus.mem_ready) |
                           ((state_q == BRANCH) & bus.zero)) & ~rst;
  assign bus.iord       = ctl_q.iord;
  assign bus.pc_src     = ctl_q.pc_src;
  assign bus.mem_to_reg = ctl_q.mem_to_reg;
  assign bus.alu_src_a  = ctl_q.alu_src_a;
  assign bus.alu_src_b  = ctl_q.alu_src_b;
  assign bus.alu_op     = ctl_q.alu_op;
  assign bus.state      = state_q;
  assign bus.illegal    = illegal_q;
  assign bus.bus_err    = bus_err_q;
  assign bus.instr_retired = retired;

endmodule
